// File: rtl/msb_normalizer.sv
// Delay-aligns accepted words with the pipelined high-bit search result, normalizes them, and queues them in a credit-controlled FIFO.
// Optional consistency checker on the search result is enabled by defining MSB_NORM_CHECK_EN.
module msb_normalizer #(
    parameter int INPUT_WIDTH    = 16,
    parameter int INDEX_WIDTH    = $clog2(INPUT_WIDTH),
    parameter int SEARCH_LATENCY = INDEX_WIDTH,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   search_valid,
    input  logic [INDEX_WIDTH-1:0] search_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] out_mantissa,
    output logic [INDEX_WIDTH-1:0] out_exponent,
    output logic                   out_zero,
    output logic                   mismatch_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INPUT_WIDTH + INDEX_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] MAX_IDX = INDEX_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic accept;
    logic pop;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Delay line: only the valid bits are reset; data simply follows in_data.
    logic [SEARCH_LATENCY-1:0] dl_valid;
    logic [INPUT_WIDTH-1:0]    dl_data [SEARCH_LATENCY];
    logic                      tap_valid;
    logic [INPUT_WIDTH-1:0]    tap_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= accept;
            for (int i = 1; i < SEARCH_LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dl_data[0] <= in_data;
        for (int i = 1; i < SEARCH_LATENCY; i++) begin
            dl_data[i] <= dl_data[i-1];
        end
    end

    assign tap_valid = dl_valid[SEARCH_LATENCY-1];
    assign tap_data  = dl_data[SEARCH_LATENCY-1];

    logic [INDEX_WIDTH-1:0] shamt;
    logic                   sh_valid;
    logic [INPUT_WIDTH-1:0] sh_mant;
    logic [INDEX_WIDTH-1:0] sh_exp;
    logic                   sh_zero;

    assign shamt = MAX_IDX - search_index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_valid <= 1'b0;
            sh_mant  <= '0;
            sh_exp   <= '0;
            sh_zero  <= 1'b0;
        end else begin
            sh_valid <= tap_valid;
            if (tap_valid) begin
                if (search_valid) begin
                    sh_mant <= tap_data << shamt;
                    sh_exp  <= search_index;
                    sh_zero <= 1'b0;
                end else begin
                    sh_mant <= '0;
                    sh_exp  <= '0;
                    sh_zero <= 1'b1;
                end
            end
        end
    end

    // Output FIFO; the credit counter guarantees a write never hits a full FIFO.
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (sh_valid) begin
                mem[wr_ptr] <= {sh_zero, sh_exp, sh_mant};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({sh_valid, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head         = mem[rd_ptr];
    assign out_valid    = (count != '0);
    assign out_mantissa = head[INPUT_WIDTH-1:0];
    assign out_exponent = head[INPUT_WIDTH +: INDEX_WIDTH];
    assign out_zero     = head[ENTRY_W-1];

    // Credit covers every word between accept and pop, so in_ready never depends on out_ready.
    logic [CNT_W-1:0] credit;
    logic             ready_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case ({accept, pop})
                2'b10:   credit <= credit + CNT_W'(1);
                2'b01:   credit <= credit - CNT_W'(1);
                default: credit <= credit;
            endcase
        end
    end

    assign in_ready = ready_en && (credit < DEPTH_CNT);

`ifdef MSB_NORM_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (tap_valid && (search_valid != (|tap_data))) begin
            err_q <= 1'b1;
        end
    end

    assign mismatch_err = err_q;
`else
    assign mismatch_err = 1'b0;
`endif

endmodule

// File: tb/tb_msb_normalizer.sv
// Bench for msb_normalizer: behavioural search stage plus a queue-based reference of normalized results.
module tb_msb_normalizer;

    localparam int W  = 16;
    localparam int IW = 4;
    localparam int L  = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          search_valid;
    logic [IW-1:0] search_index;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mantissa;
    logic [IW-1:0] out_exponent;
    logic          out_zero;
    logic          mismatch_err;
    logic          force_sv_zero = 1'b0;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int accepts = 0;
    int pops    = 0;

    typedef struct {
        logic [W-1:0]  m;
        logic [IW-1:0] e;
        logic          z;
        int            c;
    } res_t;

    res_t got_q[$];
    res_t exp_q[$];

    always #5 clk = ~clk;

    msb_normalizer #(
        .INPUT_WIDTH(W), .INDEX_WIDTH(IW), .SEARCH_LATENCY(L), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .search_valid(search_valid), .search_index(search_index),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mantissa(out_mantissa), .out_exponent(out_exponent), .out_zero(out_zero),
        .mismatch_err(mismatch_err)
    );

    function automatic int msb_of(logic [W-1:0] w);
        int r = 0;
        for (int i = 0; i < W; i++) if (w[i]) r = i;
        return r;
    endfunction

    // Free-running search stage: sees in_data every cycle, answers L cycles later.
    logic          s_v   [L];
    logic [IW-1:0] s_idx [L];

    always @(posedge clk) begin
        s_v[0]   <= |in_data;
        s_idx[0] <= IW'(msb_of(in_data));
        for (int i = 1; i < L; i++) begin
            s_v[i]   <= s_v[i-1];
            s_idx[i] <= s_idx[i-1];
        end
    end

    assign search_valid = s_v[L-1] && !force_sv_zero;
    assign search_index = s_idx[L-1];

    function automatic res_t ref_of(logic [W-1:0] w, int c);
        res_t r;
        int   e;
        e   = msb_of(w);
        r.c = c;
        if (w == '0) begin
            r.m = '0; r.e = '0; r.z = 1'b1;
        end else begin
            r.m = w << (W - 1 - e); r.e = IW'(e); r.z = 1'b0;
        end
        return r;
    endfunction

    // Advances one cycle, logging accepted words into the reference queue and popped results.
    task automatic step();
        res_t r;
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_of(in_data, cyc));
            accepts++;
        end
        if (out_valid && out_ready) begin
            r.m = out_mantissa; r.e = out_exponent; r.z = out_zero; r.c = cyc;
            got_q.push_back(r);
            pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (mismatch_err !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b expected 0", mismatch_err); end
        checks++;
        if ({out_mantissa, out_exponent, out_zero} !== '0) begin
            errors++; $display("FAIL reset_out_data: got %h/%h/%b expected 0", out_mantissa, out_exponent, out_zero);
        end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early: got %b expected 0", in_ready); end
        @(posedge clk); #1; cyc++;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b0;
        accepts = 0; pops = 0; got_q.delete(); exp_q.delete();
        repeat (12) step();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL reset_no_output: got %0d outputs expected 0", got_q.size()); end
    endtask

    task automatic test_single();
        int c0;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1; in_data = 16'h0013; in_valid = 1'b1; c0 = cyc;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        repeat (15) step();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d outputs expected 1", got_q.size());
        end else begin
            checks++; if (got_q[0].c - c0 != L + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", got_q[0].c - c0, L + 2); end
            checks++; if (got_q[0].m !== 16'h9800) begin errors++; $display("FAIL single_mantissa: got %h expected 9800", got_q[0].m); end
            checks++; if (got_q[0].e !== 4'd4) begin errors++; $display("FAIL single_exponent: got %0d expected 4", got_q[0].e); end
            checks++; if (got_q[0].z !== 1'b0) begin errors++; $display("FAIL single_zero: got %b expected 0", got_q[0].z); end
        end
    endtask

    task automatic test_zero();
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1; in_data = 16'h0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 16'hFFFF;
        repeat (12) step();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL zero_count: got %0d outputs expected 1", got_q.size());
        end else begin
            checks++;
            if ({got_q[0].z, got_q[0].m, got_q[0].e} !== {1'b1, 16'h0000, 4'd0}) begin
                errors++; $display("FAIL zero_word: got z=%b m=%h e=%0d expected z=1 m=0000 e=0", got_q[0].z, got_q[0].m, got_q[0].e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  words [3];
        logic [W-1:0]  em    [3];
        logic [IW-1:0] ee    [3];
        words[0] = 16'h8000; words[1] = 16'h0001; words[2] = 16'h00FF;
        em[0] = 16'h8000; em[1] = 16'h8000; em[2] = 16'hFF00;
        ee[0] = 4'd15;    ee[1] = 4'd0;     ee[2] = 4'd7;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            step();
        end
        in_valid = 1'b0;
        repeat (12) step();
        checks++;
        if (got_q.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d outputs expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i].m !== em[i] || got_q[i].e !== ee[i] || got_q[i].z !== 1'b0) begin
                    errors++; $display("FAIL b2b_word%0d: got m=%h e=%0d z=%b expected m=%h e=%0d z=0", i, got_q[i].m, got_q[i].e, got_q[i].z, em[i], ee[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (got_q[i].c != got_q[i-1].c + 1) begin
                        errors++; $display("FAIL b2b_spacing%0d: got gap %0d expected 1", i, got_q[i].c - got_q[i-1].c);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int max_inflight = 0;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_data = 16'($urandom);
            if (in_ready) n++;
            step();
            if (accepts - pops > max_inflight) max_inflight = accepts - pops;
        end
        checks++; if (n != D) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", n, D); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", in_ready); end
        checks++; if (max_inflight > D) begin errors++; $display("FAIL bp_credit: got %0d expected <= %0d", max_inflight, D); end
        out_ready = 1'b1; in_valid = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); end
        repeat (8) step();
        checks++;
        if (got_q.size() != D || exp_q.size() != D) begin
            errors++; $display("FAIL bp_drain_count: got %0d outputs expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < D; i++) begin
                checks++;
                if (got_q[i].m !== exp_q[i].m || got_q[i].e !== exp_q[i].e || got_q[i].z !== exp_q[i].z) begin
                    errors++; $display("FAIL bp_order%0d: got m=%h e=%0d expected m=%h e=%0d", i, got_q[i].m, got_q[i].e, exp_q[i].m, exp_q[i].e);
                end
            end
        end
    endtask

    task automatic test_random();
        int bad_ready = 0;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       in_data = 16'h0000;
                1:       in_data = 16'h0001 << $urandom_range(0, W - 1);
                default: in_data = 16'($urandom);
            endcase
            checks++;
            if (in_ready !== (accepts - pops < D)) begin
                errors++; bad_ready++;
                if (bad_ready < 5) $display("FAIL rand_in_ready: got %b expected %b at cycle %0d", in_ready, (accepts - pops < D), cyc);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) step();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d outputs expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i].m !== exp_q[i].m || got_q[i].e !== exp_q[i].e || got_q[i].z !== exp_q[i].z) begin
                    errors++; $display("FAIL rand_word%0d: got m=%h e=%0d z=%b expected m=%h e=%0d z=%b", i, got_q[i].m, got_q[i].e, got_q[i].z, exp_q[i].m, exp_q[i].e, exp_q[i].z);
                end
            end
        end
        checks++; if (mismatch_err !== 1'b0) begin errors++; $display("FAIL rand_mismatch: got %b expected 0", mismatch_err); end
    endtask

    task automatic test_reset_mid();
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h0123; step();
        in_data = 16'h4000; step();
        in_valid = 1'b0;
        repeat (8) step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_fifo_loaded: got %b expected 1", out_valid); end
        in_valid = 1'b1;
        in_data = 16'h0F00; step();
        in_data = 16'h0002; step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_async_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        accepts = 0; pops = 0; got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        repeat (15) step();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale_output: got %0d outputs expected 0", got_q.size()); end
        in_valid = 1'b1; in_data = 16'h0A00;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL mid_new_count: got %0d outputs expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0].m !== 16'hA000 || got_q[0].e !== 4'd11 || got_q[0].z !== 1'b0) begin
                errors++; $display("FAIL mid_new_word: got m=%h e=%0d expected m=A000 e=11", got_q[0].m, got_q[0].e);
            end
        end
    endtask

`ifdef MSB_NORM_CHECK_EN
    task automatic test_mismatch();
        checks++; if (mismatch_err !== 1'b0) begin errors++; $display("FAIL chk_initial: got %b expected 0", mismatch_err); end
        out_ready = 1'b1; force_sv_zero = 1'b1;
        in_valid = 1'b1; in_data = 16'h0004;
        step();
        in_valid = 1'b0; in_data = 16'h0000;
        repeat (8) step();
        force_sv_zero = 1'b0;
        checks++; if (mismatch_err !== 1'b1) begin errors++; $display("FAIL chk_set: got %b expected 1", mismatch_err); end
        repeat (10) step();
        checks++; if (mismatch_err !== 1'b1) begin errors++; $display("FAIL chk_sticky: got %b expected 1", mismatch_err); end
        rst = 1'b1;
        #1;
        checks++; if (mismatch_err !== 1'b0) begin errors++; $display("FAIL chk_cleared: got %b expected 0", mismatch_err); end
        @(posedge clk); #1;
        rst = 1'b0; accepts = 0; pops = 0;
        repeat (2) step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef MSB_NORM_CHECK_EN
        test_mismatch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msb_normalizer.md
Name: msb_normalizer

Overview:
- Downstream consumer of the pipelined high-bit search stage (free-running, no reset, no stall, latency = $clog2(INPUT_WIDTH) cycles).
- Upstream drives each accepted word into both this block and the search stage in the same cycle.
- This block delay-aligns the word with the search result, left-shifts it so the leading one lands in the MSB, and emits the normalized mantissa plus exponent (MSB index).
- A credit-controlled output FIFO with ready/valid provides backpressure, which the search stage cannot.

Parameters:
- INPUT_WIDTH, 16, data word width (power of two, >= 4).
- INDEX_WIDTH, $clog2(INPUT_WIDTH), exponent/index width.
- SEARCH_LATENCY, INDEX_WIDTH, search-stage latency in cycles; the delay line depth.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  INPUT_WIDTH  word; same value is driven to the search stage in the accept cycle.
- search_valid  in  1  search stage output_valid_flag (1 = word nonzero).
- search_index  in  INDEX_WIDTH  search stage output_data (MSB index).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts.
- out_mantissa  out  INPUT_WIDTH  normalized word.
- out_exponent  out  INDEX_WIDTH  MSB index.
- out_zero  out  1  input word was zero.
- mismatch_err  out  1  sticky consistency error (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-high, named rst; the single clock is clk.
- While rst is high:
  - Delay-line valids, shift-stage valid, FIFO pointers and count, and the credit counter are all 0.
  - out_valid=0, in_ready=0, mismatch_err=0, out_* data=0.
- Accept: a word is accepted in a cycle where in_valid && in_ready.
- Delay line:
  - SEARCH_LATENCY stages of {valid, data}; valid bits are reset, data bits are not.
  - At the tap (accept + SEARCH_LATENCY), search_valid and search_index correspond to that word and are sampled only when the tap valid is 1.
- Shift stage (one register, written when tap valid is 1):
  - Nonzero word: mantissa = data << (INPUT_WIDTH-1-search_index); exponent = search_index; zero = 0.
  - Zero word (search_valid=0): mantissa = 0; exponent = 0; zero = 1.
- FIFO:
  - Shift-stage result is written at accept + SEARCH_LATENCY + 1.
  - Data is visible and out_valid=1 one cycle later, so minimum latency from accept to out_valid is SEARCH_LATENCY+2 (6 for the default).
  - Pop on out_valid && out_ready.
  - Order is preserved; pointers wrap modulo FIFO_DEPTH.
- Credit:
  - The credit counter counts words in the delay line, shift stage and FIFO.
  - +1 on accept, -1 on pop; a simultaneous accept and pop leaves it unchanged.
  - in_ready = (credit < FIFO_DEPTH), driven from registered state only; no combinational path from out_ready.
  - A pop at cycle t makes in_ready=1 at t+1.
  - FIFO overflow is impossible by construction; a write while full never occurs.
- Empty FIFO: out_valid=0; out_* hold the last-popped value (don't care).
- Reset asserted mid-operation: all in-flight and queued words are discarded; no stale output appears after release. Stale search-stage outputs are ignored because the tap valid is 0.
- in_ready rises the first clk edge after rst deasserts.

Optional Feature:
- Macro: MSB_NORM_CHECK_EN.
- Defined: at the tap, when tap valid is 1, compare search_valid against the OR-reduction of the delayed data. On mismatch, mismatch_err is set and stays high until rst; data flow is unaffected.
- Undefined: no checker logic; mismatch_err is tied 0.

Test Plan (INPUT_WIDTH=16, FIFO_DEPTH=4, search stage instantiated on the bench):
1. Hold rst high with in_valid=1 -> out_valid=0, in_ready=0. Release rst -> in_ready=1 the next edge; no output appears.
2. Accept 16'h0013 at cycle 0, out_ready=1 -> out_valid=1 at cycle 6 with mantissa 16'h9800, exponent 4, zero 0, valid for exactly one cycle.
3. Accept 16'h0000 -> out_zero=1, mantissa 16'h0000, exponent 0.
4. Back-to-back 16'h8000, 16'h0001, 16'h00FF, out_ready=1 -> three consecutive outputs:
   - exponent 15, mantissa 16'h8000;
   - exponent 0, mantissa 16'h8000;
   - exponent 7, mantissa 16'hFF00.
5. out_ready=0, in_valid=1 continuously -> exactly 4 words accepted, then in_ready=0. Raise out_ready at cycle t -> 4 outputs in order; in_ready=1 at t+1; credit never exceeds 4.
6. Assert rst with 2 words in the delay line and 2 in the FIFO -> out_valid=0 immediately (async). After release, no output until new accepts.
   With MSB_NORM_CHECK_EN defined, force search_valid=0 for the word 16'h0004 -> mismatch_err=1 and stays high until rst.
